// File: rtl/aes_fifo_pkg.sv
// rtl/aes_fifo_pkg.sv - shared widths, block type and pack-slot helper for blk_pack_fifo
package aes_fifo_pkg;
  localparam int WORD_W        = 32;
  localparam int BLK_W         = 128;
  localparam int WORDS_PER_BLK = 4;

  typedef logic [BLK_W-1:0]  blk_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    FILL2 = 2'd2,
    FILL3 = 2'd3
  } fill_e;

  // Big-endian placement: the first word of a block lands in the top slot.
  function automatic blk_t pack_word(input blk_t blk, input fill_e slot, input word_t word);
    blk_t r;
    r = blk;
    case (slot)
      FILL0:   r[127:96] = word;
      FILL1:   r[95:64]  = word;
      FILL2:   r[63:32]  = word;
      default: r[31:0]   = word;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/blk_pack_fifo_if.sv
// rtl/blk_pack_fifo_if.sv - word-in / block-out handshake bundle; level signal only with BLK_PACK_LEVEL_EN
interface blk_pack_fifo_if
`ifdef BLK_PACK_LEVEL_EN
  #(parameter int LEVEL_W = 3)
`endif
  ;
  import aes_fifo_pkg::*;

  word_t      word_in;
  logic       word_wr;
  logic       word_rdy;
  logic       flush;
  logic       blk_deq;
  blk_t       blk_out;
  logic       blk_empty;
  logic       blk_full;
  logic [1:0] partial_cnt;
  logic       overflow;
  logic       clear_err;
`ifdef BLK_PACK_LEVEL_EN
  logic [LEVEL_W-1:0] level;

  modport master (
    output word_in, word_wr, flush, blk_deq, clear_err,
    input  word_rdy, blk_out, blk_empty, blk_full, partial_cnt, overflow, level
  );

  modport slave (
    input  word_in, word_wr, flush, blk_deq, clear_err,
    output word_rdy, blk_out, blk_empty, blk_full, partial_cnt, overflow, level
  );
`else
  modport master (
    output word_in, word_wr, flush, blk_deq, clear_err,
    input  word_rdy, blk_out, blk_empty, blk_full, partial_cnt, overflow
  );

  modport slave (
    input  word_in, word_wr, flush, blk_deq, clear_err,
    output word_rdy, blk_out, blk_empty, blk_full, partial_cnt, overflow
  );
`endif
endinterface

// File: rtl/sync_blk_fifo.sv
// rtl/sync_blk_fifo.sv - synchronous block store with show-ahead head, zero when empty
module sync_blk_fifo
  import aes_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  blk_t          push_data,
  input  logic          pop,
  output blk_t          head,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);
  blk_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a push into a full store needs.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/blk_pack_fifo.sv
// rtl/blk_pack_fifo.sv - packs 32-bit words into 128-bit blocks and queues them; BLK_PACK_LEVEL_EN adds level
module blk_pack_fifo
  import aes_fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           HCLK,
  input  logic           HRESET,
  blk_pack_fifo_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  fill_e         cnt;
  blk_t          pack;
  logic          ovf;
  logic          accept;
  logic          ovf_evt;
  logic          push;
  blk_t          push_blk;
  blk_t          head;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] count;

  // Only the word that completes a block can be refused, and only if no slot frees up this cycle.
  assign bus.word_rdy = !(cnt == FILL3 && fifo_full && !bus.blk_deq);
  assign accept       = bus.word_wr && bus.word_rdy && !bus.flush;
  assign ovf_evt      = bus.word_wr && !bus.word_rdy && !bus.flush;
  assign push_blk     = pack_word(pack, cnt, bus.word_in);
  assign push         = accept && (cnt == FILL3);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cnt  <= FILL0;
      pack <= '0;
      ovf  <= 1'b0;
    end else begin
      ovf <= ovf_evt || (ovf && !bus.clear_err);
      if (bus.flush) begin
        cnt  <= FILL0;
        pack <= '0;
      end else if (accept) begin
        cnt  <= fill_e'(cnt + 2'd1);
        pack <= push_blk;
      end
    end
  end

  sync_blk_fifo #(.DEPTH(DEPTH)) u_store (
    .clk       (HCLK),
    .rst       (HRESET),
    .push      (push),
    .push_data (push_blk),
    .pop       (bus.blk_deq),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (count)
  );

  assign bus.blk_out     = head;
  assign bus.blk_empty   = fifo_empty;
  assign bus.blk_full    = fifo_full;
  assign bus.partial_cnt = cnt;
  assign bus.overflow    = ovf;

`ifdef BLK_PACK_LEVEL_EN
  assign bus.level = count;
`else
  logic unused_count;
  assign unused_count = ^count;
`endif
endmodule

// File: tb/tb_blk_pack_fifo.sv
// tb/tb_blk_pack_fifo.sv - directed bench with queue model for blk_pack_fifo; checks level under BLK_PACK_LEVEL_EN
module tb_blk_pack_fifo;
  import aes_fifo_pkg::*;

  localparam int DEPTH = 4;
`ifdef BLK_PACK_LEVEL_EN
  localparam int CW = $clog2(DEPTH) + 1;
`endif

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  blk_pack_fifo_if
`ifdef BLK_PACK_LEVEL_EN
    #(.LEVEL_W(CW))
`endif
    bus ();

  blk_pack_fifo #(.DEPTH(DEPTH)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus.slave)
  );

  blk_t  mq[$];
  word_t mp[$];
  logic  mov = 1'b0;
  int    n_checks = 0;
  int    n_fail = 0;
  bit    chk_on = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then advance the model across the same edge.
  task automatic step(input logic rst, input logic wr, input word_t w,
                      input logic fl, input logic dq, input logic clr);
    logic rdy;
    HRESET        = rst;
    bus.word_wr   = wr;
    bus.word_in   = w;
    bus.flush     = fl;
    bus.blk_deq   = dq;
    bus.clear_err = clr;
    @(posedge HCLK);
    if (rst) begin
      mq.delete();
      mp.delete();
      mov = 1'b0;
    end else begin
      rdy = !(mp.size() == 3 && mq.size() == DEPTH && !dq);
      if (dq && mq.size() > 0) void'(mq.pop_front());
      mov = (wr && !rdy && !fl) || (mov && !clr);
      if (fl) mp.delete();
      else if (wr && rdy) begin
        mp.push_back(w);
        if (mp.size() == 4) begin
          mq.push_back({mp[0], mp[1], mp[2], mp[3]});
          mp.delete();
        end
      end
    end
    #1;
  endtask

  task automatic wr_word(input word_t w);
    step(1'b0, 1'b1, w, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic deq();
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  always @(negedge HCLK) begin
    if (chk_on) begin
      chk("m_empty", bus.blk_empty, mq.size() == 0);
      chk("m_full", bus.blk_full, mq.size() == DEPTH);
      chk("m_blk_out", bus.blk_out, (mq.size() == 0) ? 128'h0 : mq[0]);
      chk("m_partial_cnt", bus.partial_cnt, mp.size());
      chk("m_overflow", bus.overflow, mov);
      chk("m_word_rdy", bus.word_rdy, !(mp.size() == 3 && mq.size() == DEPTH && !bus.blk_deq));
`ifdef BLK_PACK_LEVEL_EN
      chk("m_level", bus.level, mq.size());
`endif
    end
  end

  initial begin
    bus.word_in = '0; bus.word_wr = 1'b0; bus.flush = 1'b0;
    bus.blk_deq = 1'b0; bus.clear_err = 1'b0;

    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
    chk_on = 1'b1;
    chk("rst_empty", bus.blk_empty, 1'b1);
    chk("rst_full", bus.blk_full, 1'b0);
    chk("rst_blk_out", bus.blk_out, 128'h0);
    chk("rst_partial", bus.partial_cnt, 2'd0);
    chk("rst_overflow", bus.overflow, 1'b0);

    wr_word(32'h00112233);
    wr_word(32'h44556677);
    wr_word(32'h8899AABB);
    chk("three_words_partial", bus.partial_cnt, 2'd3);
    chk("three_words_empty", bus.blk_empty, 1'b1);
    wr_word(32'hCCDDEEFF);
    chk("pack_blk_out", bus.blk_out, 128'h00112233445566778899AABBCCDDEEFF);
    chk("pack_empty", bus.blk_empty, 1'b0);
    chk("pack_partial", bus.partial_cnt, 2'd0);
    deq();
    chk("pop_empty", bus.blk_empty, 1'b1);

    deq();
    chk("deq_on_empty_empty", bus.blk_empty, 1'b1);
    chk("deq_on_empty_out", bus.blk_out, 128'h0);
    chk("deq_on_empty_ovf", bus.overflow, 1'b0);

    for (int i = 0; i < 16; i++) wr_word(32'hA0000000 + 32'(i));
    chk("fill_full", bus.blk_full, 1'b1);
`ifdef BLK_PACK_LEVEL_EN
    chk("fill_level", bus.level, 4);
`endif
    for (int i = 16; i < 19; i++) wr_word(32'hA0000000 + 32'(i));
    chk("fill_partial3", bus.partial_cnt, 2'd3);
    bus.word_wr = 1'b1; bus.word_in = 32'hA0000013; bus.blk_deq = 1'b0;
    #1;
    chk("refuse_rdy", bus.word_rdy, 1'b0);
    wr_word(32'hA0000013);
    chk("refuse_overflow", bus.overflow, 1'b1);
    chk("refuse_partial", bus.partial_cnt, 2'd3);
    step(1'b0, 1'b1, 32'hA0000013, 1'b0, 1'b0, 1'b1);
    chk("clear_vs_new_ovf", bus.overflow, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("clear_err", bus.overflow, 1'b0);

    step(1'b0, 1'b1, 32'hA0000013, 1'b0, 1'b1, 1'b0);
    chk("pushpop_full", bus.blk_full, 1'b1);
    chk("pushpop_head", bus.blk_out, 128'hA0000004A0000005A0000006A0000007);
    chk("pushpop_partial", bus.partial_cnt, 2'd0);
    repeat (3) deq();
    chk("drain_last", bus.blk_out, 128'hA0000010A0000011A0000012A0000013);
    deq();
    chk("drain_empty", bus.blk_empty, 1'b1);
`ifdef BLK_PACK_LEVEL_EN
    chk("drain_level", bus.level, 0);
`endif

    wr_word(32'h11111111);
    wr_word(32'h22222222);
    step(1'b0, 1'b1, 32'h33333333, 1'b1, 1'b0, 1'b0);
    chk("flush_partial", bus.partial_cnt, 2'd0);
    chk("flush_overflow", bus.overflow, 1'b0);
    chk("flush_empty", bus.blk_empty, 1'b1);
    for (int i = 0; i < 4; i++) wr_word(32'hCAFE0000 + 32'(i));
    chk("flush_clean_blk", bus.blk_out, 128'hCAFE0000CAFE0001CAFE0002CAFE0003);

    for (int i = 0; i < 4; i++) wr_word(32'hBEEF0000 + 32'(i));
    wr_word(32'h77777777);
    wr_word(32'h88888888);
    chk("prerst_partial", bus.partial_cnt, 2'd2);
    step(1'b1, 1'b1, 32'h55555555, 1'b0, 1'b1, 1'b0);
    chk("midrst_empty", bus.blk_empty, 1'b1);
    chk("midrst_blk_out", bus.blk_out, 128'h0);
    chk("midrst_partial", bus.partial_cnt, 2'd0);
    chk("midrst_overflow", bus.overflow, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("postrst_full", bus.blk_full, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/blk_pack_fifo.md
BLK_PACK_FIFO -- requirements
Module: blk_pack_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of 128-bit blocks buffered; power of two, 2..16.
REQ-002 SHALL have port HCLK  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port HRESET  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port word_in  input  32  AHB write data word to be packed.
REQ-005 SHALL have port word_wr  input  1  word_in valid this cycle.
REQ-006 SHALL have port word_rdy  output  1  word accepted if word_wr high this cycle.
REQ-007 SHALL have port flush  input  1  discard the partially assembled block.
REQ-008 SHALL have port blk_deq  input  1  pop head block this cycle.
REQ-009 SHALL have port blk_out  output  128  head block, show-ahead.
REQ-010 SHALL have port blk_empty  output  1  no complete block stored.
REQ-011 SHALL have port blk_full  output  1  DEPTH blocks stored.
REQ-012 SHALL have port partial_cnt  output  2  words held in the pack register (0..3).
REQ-013 SHALL have port overflow  output  1  sticky: a word was written while word_rdy low.
REQ-014 SHALL have port clear_err  input  1  clears overflow.

Function
REQ-015 SHALL pack words big-endian: first word to blk[127:96], second to [95:64], third to [63:32], fourth to [31:0].
REQ-016 SHALL advance the pack counter FILL0->FILL1->FILL2->FILL3->FILL0 on each accepted word; partial_cnt equals the counter.
REQ-017 SHALL push the assembled block into storage in the cycle the fourth word is accepted; blk_empty falls and blk_out shows the block on the next cycle (latency 1).
REQ-018 SHALL drive word_rdy low only when partial_cnt==3, blk_full high and blk_deq low; otherwise high (combinational).
REQ-019 SHALL ignore a word presented while word_rdy is low, leave pack state unchanged, and set overflow.
REQ-020 SHALL support simultaneous push and pop when full: occupancy stays DEPTH, head advances.
REQ-021 SHALL ignore blk_deq when blk_empty is high; no state change, no flag.
REQ-022 SHALL, on flush, return the counter to FILL0 and discard held words without touching stored blocks; flush has priority over a same-cycle word_wr (word discarded, no overflow).
REQ-023 SHALL drive blk_out to all-zero whenever blk_empty is high.
REQ-024 SHALL wrap read/write pointers modulo DEPTH; full and empty are distinguished by an occupancy count of width clog2(DEPTH)+1.
REQ-025 SHALL clear overflow on clear_err; a same-cycle new overflow event wins (flag stays set).

Reset
REQ-026 SHALL, while HRESET is high at a rising edge, set counter FILL0, pointers and occupancy 0, overflow 0, blk_empty 1, blk_full 0, blk_out 0, partial_cnt 0.
REQ-027 SHALL discard partial and stored blocks when reset occurs mid-operation; inputs during a reset cycle are ignored.
REQ-028 SHALL not require reset of the storage array contents.

Configuration
REQ-029 SHALL, with BLK_PACK_LEVEL_EN defined, add output level (clog2(DEPTH)+1 bits) equal to stored block count, updated with the same timing as blk_empty.
REQ-030 SHALL, without BLK_PACK_LEVEL_EN, omit the level port entirely; all other behaviour identical.

Structure
REQ-031 SHALL take WORD_W=32, BLK_W=128, WORDS_PER_BLK=4 and typedef blk_t (logic [127:0]) from shared package aes_fifo_pkg.
REQ-032 SHALL implement block storage in one sub-module sync_blk_fifo (push/pop/full/empty/head); packing logic stays in blk_pack_fifo.

Verification
REQ-033 SHALL check: words 0x00112233,0x44556677,0x8899AABB,0xCCDDEEFF -> one cycle later blk_out=0x00112233445566778899AABBCCDDEEFF, blk_empty=0.
REQ-034 SHALL check: 16 words with no deq (DEPTH=4) -> blk_full=1; 17th..19th accepted (partial_cnt=3); 20th word -> word_rdy=0, overflow=1, partial_cnt stays 3.
REQ-035 SHALL check: full FIFO, fourth word with blk_deq same cycle -> accepted, blk_full stays 1, head advances to the second block.
REQ-036 SHALL check: two words then flush with word_wr high -> partial_cnt=0, overflow=0, blk_empty unchanged; next four words form a clean block.
REQ-037 SHALL check: HRESET pulsed with 2 blocks stored and partial_cnt=2 -> blk_empty=1, blk_out=0, partial_cnt=0, overflow=0 next cycle.
REQ-038 SHALL check: blk_deq on empty -> no change; with BLK_PACK_LEVEL_EN, level tracks 0..4..0 across fill and drain.
